fg_prog_sequencer: RTL and testbench
====================================

FG_PROG_SEQUENCER -- requirements
Module: fg_prog_sequencer

Interface
REQ-001 SHALL have parameters, one per line:
  NUM_ROWS, 4, rows of the floating-gate array (drain-select lines).
  NUM_COLS, 8, columns of the array (gate/indirect-switch lines).
  SETUP_CYC, 4, cycles to hold address and drain select before the first pulse or measure.
  PULSE_CYC, 16, width of each injection or tunnelling pulse, in cycles.
  SETTLE_CYC, 8, cycles between the end of a pulse and the measure.
  MAX_PULSES, 255, pulse limit per command (1..255).
REQ-002 SHALL have ports, one per line:
  clk  in  1  single clock.
  rst_n  in  1  asynchronous active-low reset.
  cmd_valid  in  1  command request.
  cmd_ready  out  1  command accept.
  cmd_row  in  8  target row.
  cmd_col  in  8  target column.
  cmd_mode  in  2  00 READ, 01 INJECT, 10 TUNNEL, 11 reserved.
  abort  in  1  synchronous abort request.
  meas_hit  in  1  comparator result: target reached.
  row_addr  out  clog2(NUM_ROWS)  vertical decoder address.
  col_addr  out  clog2(NUM_COLS)  horizontal decoder address.
  drain_sel  out  NUM_ROWS  one-hot drain select.
  prog_en  out  1  program switches in program position.
  inj_pulse  out  1  injection pulse.
  tun_pulse  out  1  tunnelling pulse.
  meas_en  out  1  measure strobe.
  rsp_valid  out  1  response available.
  rsp_ready  in  1  response consumed.
  rsp_status  out  2  00 OK, 01 TIMEOUT, 10 ABORT, 11 ADDR_ERR.
  rsp_pulses  out  8  pulses applied.

Function
REQ-003 SHALL implement states IDLE, SETUP, PULSE, SETTLE, MEASURE, DONE.
REQ-004 SHALL drive cmd_ready=1 only in IDLE; a command SHALL be accepted on a clk edge with cmd_valid && cmd_ready.
REQ-005 SHALL, on accept with cmd_row>=NUM_ROWS, cmd_col>=NUM_COLS or cmd_mode=11, enter DONE with status ADDR_ERR and pulses=0, without asserting prog_en.
REQ-006 SHALL otherwise latch row, col and mode, clear the pulse counter and enter SETUP.
REQ-007 SHALL, in SETUP, PULSE, SETTLE and MEASURE, drive row_addr and col_addr from the latched values, drain_sel one-hot at the latched row, and prog_en=1.
REQ-008 SHALL stay in SETUP exactly SETUP_CYC cycles, then go to MEASURE for READ mode and to PULSE otherwise.
REQ-009 SHALL, in PULSE, assert inj_pulse (INJECT) or tun_pulse (TUNNEL) for exactly PULSE_CYC cycles; both SHALL never be high together.
REQ-010 SHALL increment the pulse counter on the last PULSE cycle, then enter SETTLE for exactly SETTLE_CYC cycles, then enter MEASURE.
REQ-011 SHALL assert meas_en for exactly one cycle in MEASURE and sample meas_hit in that same cycle.
REQ-012 SHALL leave MEASURE as follows:
  READ mode: DONE with status OK.
  meas_hit=1: DONE with status OK.
  pulse counter = MAX_PULSES: DONE with status TIMEOUT.
  otherwise: PULSE.
REQ-013 SHALL give meas_hit=1 priority over TIMEOUT in the same cycle.
REQ-014 SHALL, while abort=1 in SETUP, PULSE, SETTLE or MEASURE, enter DONE with status ABORT and the current count on the next edge.
REQ-015 SHALL ignore abort in IDLE and DONE.
REQ-016 SHALL give abort priority over every other transition.
REQ-017 SHALL, in DONE, drive prog_en, drain_sel, pulses and meas_en to 0 and hold rsp_valid=1 with stable status and pulses until rsp_ready=1, then return to IDLE.
REQ-018 SHALL, in DONE, not accept a new command until the next IDLE cycle.
REQ-019 SHALL not let the pulse counter wrap; it saturates at MAX_PULSES.

Reset
REQ-020 SHALL, while rst_n=0, go to IDLE asynchronously, mid-pulse included.
REQ-021 SHALL, while rst_n=0, drive all outputs to 0, except cmd_ready, which SHALL read 1 after reset release.
REQ-022 SHALL drop any pulse output within the reset assertion, without waiting for a clk edge.

Verification
REQ-023 Bench SHALL cover READ row 2, col 5 -> SETUP for 4 cycles, one meas_en, then rsp OK with pulses=0, with drain_sel=0100 throughout.
REQ-024 Bench SHALL cover INJECT with meas_hit=1 at the third measure -> three 16-cycle inj_pulse pulses, then rsp OK with pulses=3, and tun_pulse never high.
REQ-025 Bench SHALL cover TUNNEL with meas_hit=0 and MAX_PULSES=3 -> rsp TIMEOUT with pulses=3; then a run with meas_hit=1 on the last measure -> OK.
REQ-026 Bench SHALL cover abort in cycle 5 of the second PULSE -> pulse drops on the next edge, then rsp ABORT with pulses=1.
REQ-027 Bench SHALL cover cmd_row=4 with NUM_ROWS=4 -> rsp ADDR_ERR with pulses=0, and prog_en never high.
REQ-028 Bench SHALL cover rst_n low mid-PULSE -> inj_pulse, prog_en and rsp_valid go to 0 immediately, and cmd_ready=1 after release; plus rsp_ready held low for 10 cycles -> rsp stable and cmd_ready=0.

Source files
------------

// File: rtl/fg_prog_sequencer.sv
// Floating-gate array programming sequencer: decodes a cell address, then runs
// setup / pulse / settle / measure loops until the comparator hits, a limit or abort.
module fg_prog_sequencer #(
  parameter int NUM_ROWS   = 4,
  parameter int NUM_COLS   = 8,
  parameter int SETUP_CYC  = 4,
  parameter int PULSE_CYC  = 16,
  parameter int SETTLE_CYC = 8,
  parameter int MAX_PULSES = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [7:0]                  cmd_row,
  input  logic [7:0]                  cmd_col,
  input  logic [1:0]                  cmd_mode,
  input  logic                        abort,
  input  logic                        meas_hit,
  output logic [$clog2(NUM_ROWS)-1:0] row_addr,
  output logic [$clog2(NUM_COLS)-1:0] col_addr,
  output logic [NUM_ROWS-1:0]         drain_sel,
  output logic                        prog_en,
  output logic                        inj_pulse,
  output logic                        tun_pulse,
  output logic                        meas_en,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [1:0]                  rsp_status,
  output logic [7:0]                  rsp_pulses
);

  localparam int ROW_W   = $clog2(NUM_ROWS);
  localparam int COL_W   = $clog2(NUM_COLS);
  localparam int CYC_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int CYC_MAX = (CYC_A > SETTLE_CYC) ? CYC_A : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CYC_MAX + 1);

  localparam logic [1:0] MODE_READ   = 2'b00;
  localparam logic [1:0] MODE_INJECT = 2'b01;
  localparam logic [1:0] MODE_TUNNEL = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_TIMEOUT  = 2'b01;
  localparam logic [1:0] ST_ABORT    = 2'b10;
  localparam logic [1:0] ST_ADDR_ERR = 2'b11;

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [7:0]       MAX_CNT     = 8'(MAX_PULSES);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, SETTLE, MEASURE, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       pulse_cnt, pulse_next;
  logic [1:0]       status, status_next;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [1:0]       mode_q;
  logic             active;
  logic             addr_bad;
  logic             accept;
  logic [7:0]       pulse_inc;

  assign active    = (state == SETUP) || (state == PULSE) || (state == SETTLE) || (state == MEASURE);
  assign accept    = (state == IDLE) && cmd_valid;
  assign addr_bad  = ({1'b0, cmd_row} >= 9'(NUM_ROWS)) || ({1'b0, cmd_col} >= 9'(NUM_COLS)) ||
                     (cmd_mode == MODE_RSVD);
  assign pulse_inc = (pulse_cnt == MAX_CNT) ? pulse_cnt : pulse_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pulse_cnt <= '0;
      status    <= ST_OK;
      row_q     <= '0;
      col_q     <= '0;
      mode_q    <= MODE_READ;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pulse_cnt <= pulse_next;
      status    <= status_next;
      if (accept && !addr_bad) begin
        row_q  <= cmd_row[ROW_W-1:0];
        col_q  <= cmd_col[COL_W-1:0];
        mode_q <= cmd_mode;
      end
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    pulse_next  = pulse_cnt;
    status_next = status;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          pulse_next = '0;
          cnt_next   = '0;
          if (addr_bad) begin
            state_next  = DONE;
            status_next = ST_ADDR_ERR;
          end else begin
            state_next = SETUP;
          end
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_next   = '0;
          state_next = (mode_q == MODE_READ) ? MEASURE : PULSE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_next   = '0;
          pulse_next = pulse_inc;
          state_next = SETTLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_next   = '0;
          state_next = MEASURE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      MEASURE: begin
        cnt_next = '0;
        // A comparator hit wins over the pulse limit reached in the same measure.
        if ((mode_q == MODE_READ) || meas_hit) begin
          state_next  = DONE;
          status_next = ST_OK;
        end else if (pulse_cnt == MAX_CNT) begin
          state_next  = DONE;
          status_next = ST_TIMEOUT;
        end else begin
          state_next = PULSE;
        end
      end
      DONE: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (active && abort) begin
      state_next  = DONE;
      status_next = ST_ABORT;
      pulse_next  = pulse_cnt;
      cnt_next    = '0;
    end
  end

  // Outputs decode from state alone so an async reset clears pulses without a clock.
  always_comb begin
    cmd_ready  = rst_n && (state == IDLE);
    row_addr   = '0;
    col_addr   = '0;
    drain_sel  = '0;
    prog_en    = 1'b0;
    inj_pulse  = 1'b0;
    tun_pulse  = 1'b0;
    meas_en    = 1'b0;
    rsp_valid  = 1'b0;
    rsp_status = ST_OK;
    rsp_pulses = '0;
    if (active) begin
      row_addr         = row_q;
      col_addr         = col_q;
      drain_sel[row_q] = 1'b1;
      prog_en          = 1'b1;
    end
    if (state == PULSE) begin
      inj_pulse = (mode_q == MODE_INJECT);
      tun_pulse = (mode_q == MODE_TUNNEL);
    end
    if (state == MEASURE) meas_en = 1'b1;
    if (state == DONE) begin
      rsp_valid  = 1'b1;
      rsp_status = status;
      rsp_pulses = pulse_cnt;
    end
  end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed bench for fg_prog_sequencer: read, inject, tunnel, timeout, abort,
// address error, reset and response back-pressure cases with hand-derived results.
module tb_fg_prog_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_row;
  logic [7:0] cmd_col;
  logic [1:0] cmd_mode;
  logic       abort;
  logic       meas_hit;
  logic [1:0] row_addr;
  logic [2:0] col_addr;
  logic [3:0] drain_sel;
  logic       prog_en;
  logic       inj_pulse;
  logic       tun_pulse;
  logic       meas_en;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_status;
  logic [7:0] rsp_pulses;

  fg_prog_sequencer #(
    .NUM_ROWS(4), .NUM_COLS(8), .SETUP_CYC(4), .PULSE_CYC(16),
    .SETTLE_CYC(8), .MAX_PULSES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_mode(cmd_mode), .abort(abort),
    .meas_hit(meas_hit), .row_addr(row_addr), .col_addr(col_addr),
    .drain_sel(drain_sel), .prog_en(prog_en), .inj_pulse(inj_pulse),
    .tun_pulse(tun_pulse), .meas_en(meas_en), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_pulses(rsp_pulses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int setup_cyc, n_meas, n_pulses, inj_cyc, tun_cyc, both_high, addr_err_cyc;
  int width_bad, last_gap, gap, run, hold_bad;
  int got_rsp, got_status, got_pulses, done_outs, drop_ok, prog_seen;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [7:0] row, input logic [7:0] col, input logic [1:0] mode);
    @(negedge clk);
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_row   = row;
    cmd_col   = col;
    cmd_mode  = mode;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Runs one command to its response; hit_idx/abort_pulse of 0 mean never.
  task automatic runCommand(input int row, input int col, input int mode, input int hit_idx,
                            input int abort_pulse, input int abort_cyc);
    logic [3:0] exp_drain;
    logic       prev_p, p, abort_sent;
    exp_drain = 4'(1 << (row & 3));
    setup_cyc = 0; n_meas = 0; n_pulses = 0; inj_cyc = 0; tun_cyc = 0; both_high = 0;
    addr_err_cyc = 0; width_bad = 0; last_gap = -1; gap = 0; run = 0;
    got_rsp = 0; got_status = -1; got_pulses = -1; done_outs = -1; drop_ok = -1;
    prog_seen = 0; prev_p = 1'b0; abort_sent = 1'b0;
    applyStimulus(8'(row), 8'(col), 2'(mode));
    for (int cyc = 0; cyc < 3000 && got_rsp == 0; cyc++) begin
      @(negedge clk);
      if (abort_sent) drop_ok = (!inj_pulse && !tun_pulse && rsp_valid) ? 1 : 0;
      abort_sent = 1'b0;
      abort      = 1'b0;
      meas_hit   = 1'b0;
      if (prog_en) prog_seen = 1;
      if (rsp_valid) begin
        got_rsp    = 1;
        got_status = int'(rsp_status);
        got_pulses = int'(rsp_pulses);
        done_outs  = int'({prog_en, drain_sel, meas_en, inj_pulse, tun_pulse, cmd_ready});
      end else begin
        p = inj_pulse || tun_pulse;
        if (prog_en && (drain_sel != exp_drain || row_addr != 2'(row) || col_addr != 3'(col)))
          addr_err_cyc++;
        if (inj_pulse && tun_pulse) both_high++;
        if (inj_pulse) inj_cyc++;
        if (tun_pulse) tun_cyc++;
        if (p) begin
          if (!prev_p) begin
            n_pulses++;
            run = 0;
          end
          run++;
          if (n_pulses == abort_pulse && run == abort_cyc) begin
            abort      = 1'b1;
            abort_sent = 1'b1;
          end
        end else if (prev_p && run != 16) begin
          width_bad++;
        end
        if (prog_en && !p && !meas_en && n_pulses == 0 && n_meas == 0) setup_cyc++;
        if (prog_en && !p && !meas_en && n_pulses > 0) gap++;
        if (meas_en) begin
          n_meas++;
          last_gap = gap;
          gap      = 0;
          meas_hit = (n_meas == hit_idx);
        end
        prev_p = p;
      end
    end
    checkOutput("rsp_arrived", got_rsp, 1);
  endtask

  task automatic releaseResponse();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("cmd_ready_after_rsp", cmd_ready, 1);
    checkOutput("rsp_valid_after_rsp", rsp_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_row = '0; cmd_col = '0; cmd_mode = '0;
    abort = 1'b0; meas_hit = 1'b0; rsp_ready = 1'b0;
    #12;
    checkOutput("reset_outputs",
                {cmd_ready, row_addr, col_addr, drain_sel, prog_en, inj_pulse, tun_pulse,
                 meas_en, rsp_valid, rsp_status, rsp_pulses}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("cmd_ready_after_reset", cmd_ready, 1);

    // READ row 2, col 5
    runCommand(2, 5, 0, 0, 0, 0);
    checkOutput("read_setup_cycles", setup_cyc, 4);
    checkOutput("read_meas_count", n_meas, 1);
    checkOutput("read_pulse_count", n_pulses, 0);
    checkOutput("read_drain_addr", addr_err_cyc, 0);
    checkOutput("read_status", got_status, 0);
    checkOutput("read_pulses", got_pulses, 0);
    checkOutput("read_done_outputs", done_outs, 0);
    releaseResponse();

    // INJECT, hit on the third measure (also the limit: hit has priority)
    runCommand(1, 3, 1, 3, 0, 0);
    checkOutput("inj_pulse_count", n_pulses, 3);
    checkOutput("inj_pulse_widths", width_bad, 0);
    checkOutput("inj_high_cycles", inj_cyc, 48);
    checkOutput("inj_tun_never", tun_cyc, 0);
    checkOutput("inj_settle_gap", last_gap, 8);
    checkOutput("inj_meas_count", n_meas, 3);
    checkOutput("inj_addr", addr_err_cyc, 0);
    checkOutput("inj_status", got_status, 0);
    checkOutput("inj_pulses", got_pulses, 3);
    releaseResponse();

    // TUNNEL, no hit -> timeout after MAX_PULSES=3; then hold rsp_ready low
    runCommand(3, 7, 2, 0, 0, 0);
    checkOutput("tun_high_cycles", tun_cyc, 48);
    checkOutput("tun_inj_never", inj_cyc, 0);
    checkOutput("tun_both_high", both_high, 0);
    checkOutput("tun_status", got_status, 1);
    checkOutput("tun_pulses", got_pulses, 3);
    hold_bad  = 0;
    cmd_valid = 1'b1; cmd_row = 8'd4; cmd_col = 8'd0; cmd_mode = 2'b00;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_status != 2'd1 || rsp_pulses != 8'd3 || cmd_ready) hold_bad++;
    end
    cmd_valid = 1'b0;
    checkOutput("hold_stable", hold_bad, 0);
    releaseResponse();

    // TUNNEL, hit on the last allowed measure -> OK
    runCommand(0, 1, 2, 3, 0, 0);
    checkOutput("tun_hit_status", got_status, 0);
    checkOutput("tun_hit_pulses", got_pulses, 3);
    releaseResponse();

    // INJECT, abort in cycle 5 of the second pulse
    runCommand(2, 2, 1, 0, 2, 5);
    checkOutput("abort_pulse_drop", drop_ok, 1);
    checkOutput("abort_pulses_seen", n_pulses, 2);
    checkOutput("abort_status", got_status, 2);
    checkOutput("abort_pulses", got_pulses, 1);
    releaseResponse();

    // Address errors
    runCommand(4, 0, 1, 0, 0, 0);
    checkOutput("row_err_status", got_status, 3);
    checkOutput("row_err_pulses", got_pulses, 0);
    checkOutput("row_err_prog_en", prog_seen, 0);
    releaseResponse();
    runCommand(0, 8, 0, 0, 0, 0);
    checkOutput("col_err_status", got_status, 3);
    releaseResponse();
    runCommand(1, 1, 3, 0, 0, 0);
    checkOutput("mode_err_status", got_status, 3);
    checkOutput("mode_err_prog_en", prog_seen, 0);
    releaseResponse();

    // Reset in the middle of an injection pulse
    applyStimulus(8'd1, 8'd4, 2'b01);
    for (int cyc = 0; cyc < 100 && !inj_pulse; cyc++) @(negedge clk);
    checkOutput("reached_pulse", inj_pulse, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_inj_pulse", inj_pulse, 0);
    checkOutput("rst_prog_en", prog_en, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_cmd_ready_release", cmd_ready, 1);

    // Reset while a response is pending
    runCommand(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_done_rsp_valid", rsp_valid, 0);
    checkOutput("rst_done_status", {rsp_status, rsp_pulses}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_done_cmd_ready", cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
